pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the five-stage cached pipelined CPU. It owns the control inputs of the IF/ID register (write, flush, stall), the PC write enable and the ID/EX bubble insert. It resolves:
- load-use hazards
- ID-stage branch operand hazards
- taken-branch flushes
- data-cache-miss freezes

It applies one fixed priority and exposes optional performance counters.

## Interface
- `CNT_W`, default 16: width of each performance counter.
- `clk_i`  in  1  clock; all state updates on its rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `IF_ID_rs1_i`, `IF_ID_rs2_i`  in  5 each  source registers of the instruction in ID.
- `ID_is_branch_i`  in  1  ID holds a conditional branch (operands compared in ID).
- `branch_taken_i`  in  1  ID branch resolved taken this cycle.
- `ID_EX_rd_i`  in  5  destination register of the instruction in EX.
- `ID_EX_RegWrite_i`  in  1  EX instruction writes a register.
- `ID_EX_MemRead_i`  in  1  EX instruction is a load.
- `dcache_stall_i`  in  1  data cache busy on a miss; the whole pipeline must freeze.
- `PC_write_o`  out  1  PC update enable.
- `IF_ID_write_o`  out  1  IF/ID write enable.
- `IF_ID_flush_o`  out  1  IF/ID zeroes the captured instruction.
- `ID_EX_bubble_o`  out  1  ID/EX captures NOP control bits.
- `stall_o`  out  1  global freeze for all pipeline registers.
- `stall_cnt_o`, `bubble_cnt_o`, `flush_cnt_o`  out  `CNT_W` each  performance counters.
- `miss_cnt_o`  out  `CNT_W`  performance counter.

## Operation
- States:
  - RUN: normal.
  - HOLD: extra branch-after-load bubble pending.
  - MISS: cache freeze in progress.
- Hazard terms; any rd of 0 never matches:
  - dep = `ID_EX_rd_i` equals `IF_ID_rs1_i` or `IF_ID_rs2_i`.
  - load_use = `ID_EX_MemRead_i` & dep.
  - br_alu = `ID_is_branch_i` & `ID_EX_RegWrite_i` & !`ID_EX_MemRead_i` & dep.
  - br_load = `ID_is_branch_i` & load_use.
- Priority, highest first: cache stall > HOLD > load_use/br_alu > taken-branch flush > none.
- Cache stall (`dcache_stall_i`=1, any state):
  - `stall_o`=1, `PC_write_o`=0, `IF_ID_write_o`=0.
  - All hazard outputs are 0; hazard detection is suppressed.
  - Enter MISS. RUN or HOLD → MISS counts one miss event.
  - Leaving MISS returns to the state saved on entry (RUN or HOLD), with the HOLD obligation intact.
- load_use or br_alu (RUN, no cache stall): `PC_write_o`=0, `IF_ID_write_o`=0, `ID_EX_bubble_o`=1 for the current cycle.
  - Additionally, br_load transitions to HOLD.
- HOLD (no cache stall): `PC_write_o`=0, `IF_ID_write_o`=0, `ID_EX_bubble_o`=1, then → RUN. Total branch-after-load bubbles = 2.
- Taken branch (RUN, no hazard): `IF_ID_flush_o`=1; `PC_write_o`=1 and `IF_ID_write_o`=1 so the target is fetched.
- A taken branch together with a hazard: the hazard wins and the flush is not asserted. The branch re-resolves once operands are valid.
- Default: `PC_write_o`=`IF_ID_write_o`=1; all other outputs 0.

## Timing
- All control outputs are combinational from state plus inputs, valid in the same cycle. State and counters are registered.
- Reset (`rst_i`=1, sampled at posedge):
  - Next state RUN; counters 0; saved state RUN.
  - While `rst_i` is high, outputs are forced: `PC_write_o`=0, `IF_ID_write_o`=0, `IF_ID_flush_o`=1, `ID_EX_bubble_o`=1, `stall_o`=0.
- Reset mid-MISS or mid-HOLD discards the pending state.
- Load-use costs exactly 1 cycle. Branch-after-ALU costs 1 cycle. Branch-after-load costs 2 cycles. A miss costs as many cycles as `dcache_stall_i` is high; no extra release cycle.
- `dcache_stall_i` rising in the same cycle the FSM would enter HOLD: the saved state is HOLD.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - Four `CNT_W`-bit saturating counters (hold at all-ones).
  - Increments:
    - `stall_cnt_o` per cycle with `stall_o`=1.
    - `bubble_cnt_o` per cycle with `ID_EX_bubble_o`=1.
    - `flush_cnt_o` per cycle with `IF_ID_flush_o`=1.
    - `miss_cnt_o` per MISS entry.
  - Reset-mode forced outputs are not counted.
- Undefined: counter outputs tied to 0 and no counter flops are generated. Control behaviour is identical.

## Structure
- Shared package `pipe_ctrl_pkg`: state enum (RUN, HOLD, MISS), `REG_ZERO` = 5'd0, `CNT_W` default.
- One natural sub-module: `hazard_detect`, purely combinational, producing load_use / br_alu / br_load.
- The FSM, output mux and counters live in the top.

## Test plan
- Load x5 in EX (`ID_EX_MemRead_i`=1, rd=5) and ID rs1=5 → one cycle with `PC_write_o`=0, `IF_ID_write_o`=0, `ID_EX_bubble_o`=1, then defaults.
- Branch in ID on rs2=7 after load rd=7 → exactly 2 bubble cycles (second from HOLD). With `PIPE_CTRL_PERF_EN`, `bubble_cnt_o`=2.
- Taken branch with no dependency → `IF_ID_flush_o`=1 for 1 cycle with `PC_write_o`=1. Same stimulus with a load rd=0 in EX → still a flush and no bubble.
- `dcache_stall_i` high for 10 cycles, starting the cycle HOLD is entered → `stall_o`=1 for 10 cycles, then one HOLD bubble. `miss_cnt_o`=1, `stall_cnt_o`=10.
- `rst_i` asserted during MISS → next cycle RUN, counters 0. Forced reset outputs during reset. Defaults after `rst_i` drops with idle inputs.
- Drive `flush_cnt_o` to all-ones with `CNT_W`=4 (16 taken branches) → it saturates at 4'hF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Holds the FSM state enum, the hard-wired zero register index and the counter width default.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    MISS = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO      = 5'd0;
  localparam int         CNT_W_DEFAULT = 16;

  // x0 is hard-wired, so a destination of x0 can never create a dependency
  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != REG_ZERO) && (rd == rs);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational hazard classifier for the instruction in ID against the one in EX.
// Produces the load-use, branch-after-ALU and branch-after-load terms.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] IF_ID_rs1,
  input  logic [4:0] IF_ID_rs2,
  input  logic       ID_is_branch,
  input  logic [4:0] ID_EX_rd,
  input  logic       ID_EX_RegWrite,
  input  logic       ID_EX_MemRead,
  output logic       load_use,
  output logic       br_alu,
  output logic       br_load
);

  logic dep;

  assign dep      = reg_match(ID_EX_rd, IF_ID_rs1) | reg_match(ID_EX_rd, IF_ID_rs2);
  assign load_use = ID_EX_MemRead & dep;
  // ALU results are not forwardable into the ID-stage comparator, so a branch must wait one cycle
  assign br_alu   = ID_is_branch & ID_EX_RegWrite & ~ID_EX_MemRead & dep;
  assign br_load  = ID_is_branch & load_use;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer: FSM (RUN/HOLD/MISS), prioritised control mux and perf counters.
// Perf counters are built only when PIPE_CTRL_PERF_EN is defined; otherwise they read as zero.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IF_ID_rs1_i,
  input  logic [4:0]       IF_ID_rs2_i,
  input  logic             ID_is_branch_i,
  input  logic             branch_taken_i,
  input  logic [4:0]       ID_EX_rd_i,
  input  logic             ID_EX_RegWrite_i,
  input  logic             ID_EX_MemRead_i,
  input  logic             dcache_stall_i,
  output logic             PC_write_o,
  output logic             IF_ID_write_o,
  output logic             IF_ID_flush_o,
  output logic             ID_EX_bubble_o,
  output logic             stall_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  state_e state_reg, state_next;
  state_e saved_reg, saved_next;
  state_e eff_state;
  logic   load_use, br_alu, br_load;

  hazard_detect u_hazard_detect (
    .IF_ID_rs1      (IF_ID_rs1_i),
    .IF_ID_rs2      (IF_ID_rs2_i),
    .ID_is_branch   (ID_is_branch_i),
    .ID_EX_rd       (ID_EX_rd_i),
    .ID_EX_RegWrite (ID_EX_RegWrite_i),
    .ID_EX_MemRead  (ID_EX_MemRead_i),
    .load_use       (load_use),
    .br_alu         (br_alu),
    .br_load        (br_load)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= RUN;
      saved_reg <= RUN;
    end else begin
      state_reg <= state_next;
      saved_reg <= saved_next;
    end
  end

  // Once the miss releases, act on the saved state in that same cycle: no release bubble
  assign eff_state = (state_reg == MISS) ? saved_reg : state_reg;

  always_comb begin
    state_next     = state_reg;
    saved_next     = saved_reg;
    PC_write_o     = 1'b1;
    IF_ID_write_o  = 1'b1;
    IF_ID_flush_o  = 1'b0;
    ID_EX_bubble_o = 1'b0;
    stall_o        = 1'b0;

    if (dcache_stall_i) begin
      stall_o       = 1'b1;
      PC_write_o    = 1'b0;
      IF_ID_write_o = 1'b0;
      state_next    = MISS;
      if (state_reg != MISS) begin
        // A branch-after-load seen on the entry cycle still owes its HOLD bubble
        saved_next = (state_reg == RUN && br_load) ? HOLD : state_reg;
      end
    end else begin
      case (eff_state)
        HOLD: begin
          PC_write_o     = 1'b0;
          IF_ID_write_o  = 1'b0;
          ID_EX_bubble_o = 1'b1;
          state_next     = RUN;
        end
        default: begin
          state_next = RUN;
          if (load_use || br_alu) begin
            PC_write_o     = 1'b0;
            IF_ID_write_o  = 1'b0;
            ID_EX_bubble_o = 1'b1;
            if (br_load) state_next = HOLD;
          end else if (branch_taken_i) begin
            IF_ID_flush_o = 1'b1;
          end
        end
      endcase
    end

    if (rst_i) begin
      PC_write_o     = 1'b0;
      IF_ID_write_o  = 1'b0;
      IF_ID_flush_o  = 1'b1;
      ID_EX_bubble_o = 1'b1;
      stall_o        = 1'b0;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [3:0]            cnt_inc;
  logic [3:0][CNT_W-1:0] cnt_val;

  assign cnt_inc = {dcache_stall_i && (state_reg != MISS), IF_ID_flush_o, ID_EX_bubble_o, stall_o};

  for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
    logic [CNT_W-1:0] count_reg;

    // Reset has priority, so forced reset-mode outputs are never counted
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        count_reg <= '0;
      end else if (cnt_inc[gi] && (count_reg != {CNT_W{1'b1}})) begin
        count_reg <= count_reg + 1'b1;
      end
    end

    assign cnt_val[gi] = count_reg;
  end

  assign stall_cnt_o  = cnt_val[0];
  assign bubble_cnt_o = cnt_val[1];
  assign flush_cnt_o  = cnt_val[2];
  assign miss_cnt_o   = cnt_val[3];
`else
  assign stall_cnt_o  = '0;
  assign bubble_cnt_o = '0;
  assign flush_cnt_o  = '0;
  assign miss_cnt_o   = '0;
`endif

endmodule
